// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and widths for the game-state sequencer
package game_pkg;

    typedef enum logic [2:0] {
        PLAY,
        HIT_PAUSE,
        WON,
        LOST,
        RESTART
    } game_state_t;

    localparam int FRAME_CNT_WIDTH = 8;
    localparam int LIVES_WIDTH     = 3;
    localparam int SCORE_WIDTH     = 16;

endpackage

// File: rtl/game_controller_if.sv
// rtl/game_controller_if.sv - game events in, game status/control out
interface game_controller_if #(
    parameter int LIVES_WIDTH = game_pkg::LIVES_WIDTH,
    parameter int SCORE_WIDTH = game_pkg::SCORE_WIDTH
);
    logic                   startOfFrame;
    logic                   player_hit;
    logic                   enemy_killed;
    logic                   all_enemies_dead;
    logic                   enemies_landed;
    logic                   start_key;
    logic                   game_won;
    logic                   game_over;
    logic                   freeze;
    logic                   game_restart;
    logic [LIVES_WIDTH-1:0] lives;
    logic [SCORE_WIDTH-1:0] score;

    modport master (
        output startOfFrame, player_hit, enemy_killed, all_enemies_dead, enemies_landed, start_key,
        input  game_won, game_over, freeze, game_restart, lives, score
    );

    modport slave (
        input  startOfFrame, player_hit, enemy_killed, all_enemies_dead, enemies_landed, start_key,
        output game_won, game_over, freeze, game_restart, lives, score
    );
endinterface

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - loadable frame down-counter, saturating at zero
module frame_timer
    import game_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [FRAME_CNT_WIDTH-1:0] load_value,
    input  logic                       startOfFrame,
    output logic                       done,
    output logic [FRAME_CNT_WIDTH-1:0] count
);
    logic [FRAME_CNT_WIDTH-1:0] r_count;

    // A load coinciding with a frame pulse wins; that frame is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (startOfFrame && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done  = (r_count == '0);
    assign count = r_count;
endmodule

// File: rtl/game_controller.sv
// rtl/game_controller.sv - game-state sequencer: lives, score, win/loss, freeze and restart
module game_controller #(
    parameter int LIVES_WIDTH      = game_pkg::LIVES_WIDTH,
    parameter int INITIAL_LIVES    = 3,
    parameter int SCORE_WIDTH      = game_pkg::SCORE_WIDTH,
    parameter int POINTS_PER_KILL  = 10,
    parameter int HIT_PAUSE_FRAMES = 60,
    parameter int END_LOCK_FRAMES  = 30
) (
    input  logic              clk,
    input  logic              reset,
    game_controller_if.slave  bus
);
    import game_pkg::*;

    game_state_t                r_state;
    game_state_t                w_next;
    logic [LIVES_WIDTH-1:0]     r_lives;
    logic [LIVES_WIDTH-1:0]     w_lives_next;
    logic [SCORE_WIDTH-1:0]     r_score;
    logic [SCORE_WIDTH-1:0]     w_score_next;
    logic [SCORE_WIDTH:0]       w_score_sum;
    logic [SCORE_WIDTH-1:0]     w_score_sat;
    logic                       r_key_prev;
    logic                       w_key_rise;
    logic                       w_load;
    logic [FRAME_CNT_WIDTH-1:0] w_load_value;
    logic                       w_timer_done;
    logic [FRAME_CNT_WIDTH-1:0] w_timer_count;
    logic                       r_game_won;
    logic                       r_game_over;
    logic                       r_freeze;
    logic                       r_game_restart;

    frame_timer u_frame_timer (
        .clk          (clk),
        .reset        (reset),
        .load         (w_load),
        .load_value   (w_load_value),
        .startOfFrame (bus.startOfFrame),
        .done         (w_timer_done),
        .count        (w_timer_count)
    );

    assign w_key_rise  = bus.start_key && !r_key_prev;
    assign w_score_sum = {1'b0, r_score} + (SCORE_WIDTH+1)'(POINTS_PER_KILL);
    assign w_score_sat = w_score_sum[SCORE_WIDTH] ? '1 : w_score_sum[SCORE_WIDTH-1:0];

    always_comb begin
        w_next       = r_state;
        w_lives_next = r_lives;
        w_score_next = r_score;
        w_load       = 1'b0;
        w_load_value = FRAME_CNT_WIDTH'(END_LOCK_FRAMES);

        if (((r_state == PLAY) || (r_state == HIT_PAUSE)) && bus.enemy_killed) begin
            w_score_next = w_score_sat;
        end

        case (r_state)
            PLAY: begin
                // Every loss path is checked before the win path.
                if (bus.player_hit && (r_lives <= LIVES_WIDTH'(1))) begin
                    w_lives_next = '0;
                    w_next       = LOST;
                    w_load       = 1'b1;
                end else if (bus.enemies_landed) begin
                    w_next = LOST;
                    w_load = 1'b1;
                end else if (bus.player_hit) begin
                    w_lives_next = r_lives - 1'b1;
                    w_next       = HIT_PAUSE;
                    w_load       = 1'b1;
                    w_load_value = FRAME_CNT_WIDTH'(HIT_PAUSE_FRAMES);
                end else if (bus.all_enemies_dead) begin
                    w_next = WON;
                    w_load = 1'b1;
                end
            end
            HIT_PAUSE: begin
                if (bus.startOfFrame && (w_timer_count == FRAME_CNT_WIDTH'(1))) begin
                    w_next = PLAY;
                end
            end
            WON, LOST: begin
                if (w_key_rise && w_timer_done) begin
                    w_next       = RESTART;
                    w_lives_next = LIVES_WIDTH'(INITIAL_LIVES);
                    w_score_next = '0;
                end
            end
            RESTART: w_next = PLAY;
            default: w_next = PLAY;
        endcase
    end

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= PLAY;
            r_lives        <= LIVES_WIDTH'(INITIAL_LIVES);
            r_score        <= '0;
            r_key_prev     <= 1'b1;
            r_game_won     <= 1'b0;
            r_game_over    <= 1'b0;
            r_freeze       <= 1'b0;
            r_game_restart <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_lives        <= w_lives_next;
            r_score        <= w_score_next;
            r_key_prev     <= bus.start_key;
            r_game_won     <= (w_next == WON);
            r_game_over    <= (w_next == LOST);
            r_freeze       <= (w_next != PLAY);
            r_game_restart <= (w_next == RESTART);
        end
    end

    assign bus.game_won     = r_game_won;
    assign bus.game_over    = r_game_over;
    assign bus.freeze       = r_freeze;
    assign bus.game_restart = r_game_restart;
    assign bus.lives        = r_lives;
    assign bus.score        = r_score;
endmodule
